// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator.
// Mode encodings and a legality helper used by decode and the extender.
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_Z8  = 3'b000,
        IMM_Z12 = 3'b001,
        IMM_BR  = 3'b010,
        IMM_ROT = 3'b011,
        IMM_S12 = 3'b100
    } imm_src_e;

    function automatic logic is_legal_src(
        input logic [IMM_SRC_W-1:0] src
    );
        return src <= IMM_S12;
    endfunction

endpackage

// File: rtl/imm_rotator.sv
// ARM rotated imm8: 32-bit rotate right of imm8 by 2*rot4.
// Shifter carry is the result MSB, or carry_in when no rotation.
module imm_rotator (
    input  logic [7:0]  imm8,
    input  logic [3:0]  rot4,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out
);

    logic [31:0] word;
    logic [4:0]  amt;

    always_comb begin
        word      = {24'd0, imm8};
        amt       = {rot4, 1'b0};
        // low half of a doubled word shifted right is a rotate
        result    = 32'({word, word} >> amt);
        carry_out = (rot4 == 4'd0) ? carry_in : result[31];
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender with flush and illegal flag.
// S1 holds raw fields; the mode mux sits between S1 and S2.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int INSTR_W  = 24,
    parameter int BR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic [2:0]         ImmSrc,
    input  logic               carry_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  ExtImm,
    output logic               carry_out,
    output logic               illegal
);

    logic               s1_valid_q, s1_valid_d;
    logic [INSTR_W-1:0] s1_instr_q, s1_instr_d;
    logic [2:0]         s1_src_q, s1_src_d;
    logic               s1_cin_q, s1_cin_d;

    logic               s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]  s2_imm_q, s2_imm_d;
    logic               s2_cout_q, s2_cout_d;
    logic               s2_ill_q, s2_ill_d;

    logic               accept;
    logic               s2_load;
    logic [31:0]        rot_res;
    logic               rot_cout;
    logic [DATA_W-1:0]  imm_mux;
    logic               cout_mux;
    logic               ill_mux;

    logic signed [INSTR_W+BR_SHIFT-1:0] br_raw;
    logic signed [11:0]                 s12_raw;

    imm_rotator u_rot (
        .imm8      (s1_instr_q[7:0]),
        .rot4      (s1_instr_q[11:8]),
        .carry_in  (s1_cin_q),
        .result    (rot_res),
        .carry_out (rot_cout)
    );

    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !flush && (!s1_valid_q || s2_load);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        br_raw   = {s1_instr_q, {BR_SHIFT{1'b0}}};
        s12_raw  = s1_instr_q[11:0];
        imm_mux  = '0;
        cout_mux = s1_cin_q;
        ill_mux  = !is_legal_src(s1_src_q);
        unique case (s1_src_q)
            IMM_Z8:  imm_mux = DATA_W'(s1_instr_q[7:0]);
            IMM_Z12: imm_mux = DATA_W'(s1_instr_q[11:0]);
            IMM_BR:  imm_mux = DATA_W'(br_raw);
            IMM_ROT: begin
                imm_mux  = DATA_W'(rot_res);
                cout_mux = rot_cout;
            end
            IMM_S12: imm_mux = DATA_W'(s12_raw);
            default: imm_mux = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        s1_src_d   = s1_src_q;
        s1_cin_d   = s1_cin_q;
        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_cout_d  = s2_cout_q;
        s2_ill_d   = s2_ill_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_instr_d = Instruction;
            s1_src_d   = ImmSrc;
            s1_cin_d   = carry_in;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_imm_d   = imm_mux;
            s2_cout_d  = cout_mux;
            s2_ill_d   = ill_mux;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
        // a taken branch kills everything in flight
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_src_q   <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_cout_q  <= 1'b0;
            s2_ill_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_instr_q <= s1_instr_d;
            s1_src_q   <= s1_src_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_cout_q  <= s2_cout_d;
            s2_ill_q   <= s2_ill_d;
        end
    end

    always_comb begin
        out_valid = s2_valid_q;
        ExtImm    = s2_imm_q;
        carry_out = s2_cout_q;
        illegal   = s2_ill_q;
    end

endmodule
